player_hit_detect: RTL and testbench



---
 rtl/player_hit_detect_if.sv | 27 ++
 rtl/player_hit_detect.sv | 152 +++++++++++++++
 tb/tb_player_hit_detect.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/player_hit_detect_if.sv
// Frame-rate bus between the game logic and the player hit detector: missile/player positions in, collision code and player status out.
interface player_hit_detect_if;
  logic       frame;
  logic       restart;
  logic [9:0] player_x;
  logic [9:0] m1_x;
  logic [9:0] m1_y;
  logic [9:0] m2_x;
  logic [9:0] m2_y;
  logic [9:0] m3_x;
  logic [9:0] m3_y;
  logic [1:0] player_collision;
  logic [2:0] lives;
  logic       player_hit;
  logic       player_visible;
  logic       game_over;

  modport master (
    output frame, restart, player_x, m1_x, m1_y, m2_x, m2_y, m3_x, m3_y,
    input  player_collision, lives, player_hit, player_visible, game_over
  );

  modport slave (
    input  frame, restart, player_x, m1_x, m1_y, m2_x, m2_y, m3_x, m3_y,
    output player_collision, lives, player_hit, player_visible, game_over
  );
endinterface

// File: rtl/player_hit_detect.sv
// Player hit detection: missile/player box overlap, lives, HIT/INVULN/GAME_OVER timing; collision code registered on frame (1 cycle).
// Optional PLAYER_HIT_BLINK_EN: player blinks (4 frames on, 4 off) while invulnerable.
module player_hit_detect #(
  parameter int PLAYER_Y      = 440,
  parameter int PLAYER_W      = 26,
  parameter int PLAYER_H      = 16,
  parameter int PROJ_W        = 3,
  parameter int PROJ_H        = 12,
  parameter int START_LIVES   = 3,
  parameter int HIT_FRAMES    = 32,
  parameter int INVULN_FRAMES = 64
) (
  input logic              clk,
  input logic              rst,
  player_hit_detect_if.slave bus
);

  localparam logic [10:0] PY       = 11'(PLAYER_Y);
  localparam logic [10:0] PW       = 11'(PLAYER_W);
  localparam logic [10:0] PH       = 11'(PLAYER_H);
  localparam logic [10:0] MW       = 11'(PROJ_W);
  localparam logic [10:0] MH       = 11'(PROJ_H);
  localparam logic [2:0]  LIVES0   = 3'(START_LIVES);
  localparam logic [7:0]  HIT_LAST = 8'(HIT_FRAMES - 1);
  localparam logic [7:0]  INV_LAST = 8'(INVULN_FRAMES - 1);

  typedef enum logic [1:0] {
    ALIVE,
    HIT,
    INVULN,
    GAME_OVER
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [2:0] lives_q, lives_d;
  logic [1:0] coll_q, coll_d;
  logic       ov1, ov2, ov3;
  logic [1:0] hit_idx;

  // Sums zero-extended to 11 bits so a player near x=1023 cannot wrap; strict compares make edge contact a miss.
  function automatic logic overlap(input logic [9:0] mx, input logic [9:0] my, input logic [9:0] px);
    logic [10:0] mx_w, my_w, px_w;
    mx_w = {1'b0, mx};
    my_w = {1'b0, my};
    px_w = {1'b0, px};
    return (mx_w < px_w + PW) && (px_w < mx_w + MW) &&
           (my_w < PY + PH)   && (PY < my_w + MH);
  endfunction

  assign ov1 = overlap(bus.m1_x, bus.m1_y, bus.player_x);
  assign ov2 = overlap(bus.m2_x, bus.m2_y, bus.player_x);
  assign ov3 = overlap(bus.m3_x, bus.m3_y, bus.player_x);

  always_comb begin
    hit_idx = 2'd0;
    if (ov1)      hit_idx = 2'd1;
    else if (ov2) hit_idx = 2'd2;
    else if (ov3) hit_idx = 2'd3;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ALIVE;
      timer_q <= 8'd0;
      lives_q <= LIVES0;
      coll_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lives_q <= lives_d;
      coll_q  <= coll_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    lives_d = lives_q;
    coll_d  = coll_q;
    if (bus.restart) begin
      state_d = ALIVE;
      timer_d = 8'd0;
      lives_d = LIVES0;
      coll_d  = 2'd0;
    end else if (bus.frame) begin
      // The code is reported in every state so the missile block always respawns the hitting missile.
      coll_d = hit_idx;
      unique case (state_q)
        ALIVE: begin
          if (hit_idx != 2'd0) begin
            if (lives_q <= 3'd1) begin
              lives_d = 3'd0;
              state_d = GAME_OVER;
            end else begin
              lives_d = lives_q - 3'd1;
              state_d = HIT;
              timer_d = 8'd0;
            end
          end
        end
        HIT: begin
          if (timer_q == HIT_LAST) begin
            state_d = INVULN;
            timer_d = 8'd0;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
        INVULN: begin
          if (timer_q == INV_LAST) begin
            state_d = ALIVE;
            timer_d = 8'd0;
          end else begin
            timer_d = timer_q + 8'd1;
          end
        end
        GAME_OVER: lives_d = 3'd0;
        default:   state_d = ALIVE;
      endcase
    end
  end

  always_comb begin
    bus.player_hit     = 1'b0;
    bus.player_visible = 1'b1;
    bus.game_over      = 1'b0;
    unique case (state_q)
      ALIVE: ;
      HIT: begin
        bus.player_hit     = 1'b1;
        bus.player_visible = 1'b0;
      end
      INVULN: begin
`ifdef PLAYER_HIT_BLINK_EN
        bus.player_visible = ~timer_q[2];
`else
        bus.player_visible = 1'b1;
`endif
      end
      GAME_OVER: begin
        bus.player_visible = 1'b0;
        bus.game_over      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.player_collision = coll_q;
  assign bus.lives            = lives_q;

endmodule

// File: tb/tb_player_hit_detect.sv
// Bench for player_hit_detect: directed scenarios plus randomized frames against a frame-count model.
module tb_player_hit_detect;
  localparam int HF = 32;
  localparam int IF = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // Model: lives, sticky over flag, frame number of the last life-costing hit, frames processed.
  int m_lives, m_over, m_hit_at, m_fno, m_coll;

  player_hit_detect_if bus ();

  player_hit_detect dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic bit ovl(int mx, int my, int px);
    return (mx < px + 26) && (px < mx + 3) && (my < 440 + 16) && (440 < my + 12);
  endfunction

  function automatic int model_idx();
    if (ovl(int'(bus.m1_x), int'(bus.m1_y), int'(bus.player_x))) return 1;
    if (ovl(int'(bus.m2_x), int'(bus.m2_y), int'(bus.player_x))) return 2;
    if (ovl(int'(bus.m3_x), int'(bus.m3_y), int'(bus.player_x))) return 3;
    return 0;
  endfunction

  // 0 alive, 1 exploding, 2 invulnerable, 3 game over; derived from frames since the hit.
  function automatic int phase();
    int d;
    d = m_fno - m_hit_at;
    if (m_over != 0) return 3;
    if (d >= 1 && d <= HF) return 1;
    if (d > HF && d <= HF + IF) return 2;
    return 0;
  endfunction

  function automatic int exp_hit();
    return (phase() == 1) ? 1 : 0;
  endfunction

  function automatic int exp_vis();
    int p, d;
    p = phase();
    d = m_fno - m_hit_at - HF - 1;
    if (p == 0) return 1;
    if (p == 2) begin
`ifdef PLAYER_HIT_BLINK_EN
      return ((d / 4) % 2 == 0) ? 1 : 0;
`else
      return (d >= 0) ? 1 : 1;
`endif
    end
    return 0;
  endfunction

  task automatic model_restart();
    m_lives  = 3;
    m_over   = 0;
    m_hit_at = m_fno - 1000;
    m_coll   = 0;
  endtask

  task automatic set_pos(int px, int x1, int y1, int x2, int y2, int x3, int y3);
    bus.player_x = 10'(px);
    bus.m1_x = 10'(x1); bus.m1_y = 10'(y1);
    bus.m2_x = 10'(x2); bus.m2_y = 10'(y2);
    bus.m3_x = 10'(x3); bus.m3_y = 10'(y3);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_frame();
    int idx;
    idx = model_idx();
    m_coll = idx;
    if (m_over == 0 && phase() == 0 && idx != 0) begin
      if (m_lives == 1) begin
        m_lives = 0;
        m_over  = 1;
      end else begin
        m_lives  = m_lives - 1;
        m_hit_at = m_fno;
      end
    end
    m_fno = m_fno + 1;
    bus.frame = 1'b1;
    @(posedge clk);
    #1;
    bus.frame = 1'b0;
  endtask

  task automatic do_restart(bit with_frame);
    bus.restart = 1'b1;
    bus.frame   = with_frame;
    @(posedge clk);
    #1;
    bus.restart = 1'b0;
    bus.frame   = 1'b0;
    model_restart();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    m_fno = 0;
    model_restart();
    checks++; if (bus.player_collision !== 2'd0) begin errors++; $display("FAIL reset_coll got %0d exp 0", bus.player_collision); end
    checks++; if (bus.lives !== 3'd3) begin errors++; $display("FAIL reset_lives got %0d exp 3", bus.lives); end
    checks++; if (bus.player_hit !== 1'b0) begin errors++; $display("FAIL reset_hit got %0b exp 0", bus.player_hit); end
    checks++; if (bus.player_visible !== 1'b1) begin errors++; $display("FAIL reset_vis got %0b exp 1", bus.player_visible); end
    checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL reset_go got %0b exp 0", bus.game_over); end
  endtask

  task automatic test_basic_hit();
    set_pos(300, 310, 445, 0, 0, 0, 0);
    idle(2);
    checks++; if (bus.player_collision !== 2'd0) begin errors++; $display("FAIL nofr_coll got %0d exp 0", bus.player_collision); end
    do_frame();
    checks++; if (bus.player_collision !== 2'd1) begin errors++; $display("FAIL hit_coll got %0d exp 1", bus.player_collision); end
    checks++; if (bus.lives !== 3'd2) begin errors++; $display("FAIL hit_lives got %0d exp 2", bus.lives); end
    checks++; if (bus.player_hit !== 1'b1) begin errors++; $display("FAIL hit_flag got %0b exp 1", bus.player_hit); end
    checks++; if (bus.player_visible !== 1'b0) begin errors++; $display("FAIL hit_vis got %0b exp 0", bus.player_visible); end
    set_pos(300, 0, 0, 0, 0, 0, 0);
    idle(4);
    checks++; if (bus.player_collision !== 2'd1) begin errors++; $display("FAIL hold_coll got %0d exp 1", bus.player_collision); end
    do_frame();
    checks++; if (bus.player_collision !== 2'd0) begin errors++; $display("FAIL clear_coll got %0d exp 0", bus.player_collision); end
  endtask

  task automatic test_edges();
    do_restart(1'b0);
    checks++; if (bus.lives !== 3'd3) begin errors++; $display("FAIL rst_lives got %0d exp 3", bus.lives); end
    set_pos(300, 297, 445, 326, 445, 310, 428);
    do_frame();
    checks++; if (bus.player_collision !== 2'd0) begin errors++; $display("FAIL edge_coll got %0d exp 0", bus.player_collision); end
    checks++; if (bus.lives !== 3'd3) begin errors++; $display("FAIL edge_lives got %0d exp 3", bus.lives); end
    // Near the right screen edge the box sum exceeds 10 bits.
    set_pos(1010, 0, 0, 1020, 450, 0, 0);
    do_frame();
    checks++; if (bus.player_collision !== 2'd2) begin errors++; $display("FAIL wide_coll got %0d exp 2", bus.player_collision); end
    checks++; if (bus.lives !== 3'(m_lives)) begin errors++; $display("FAIL wide_lives got %0d exp %0d", bus.lives, m_lives); end
  endtask

  task automatic test_priority_windows();
    do_restart(1'b0);
    set_pos(300, 305, 450, 0, 0, 320, 435);
    do_frame();
    checks++; if (bus.player_collision !== 2'd1) begin errors++; $display("FAIL prio_coll got %0d exp 1", bus.player_collision); end
    checks++; if (bus.lives !== 3'd2) begin errors++; $display("FAIL prio_lives got %0d exp 2", bus.lives); end
    set_pos(300, 0, 0, 0, 0, 320, 435);
    for (int f = 0; f < HF + IF; f++) begin
      do_frame();
      checks++; if (bus.player_collision !== 2'd3) begin errors++; $display("FAIL win_coll f=%0d got %0d exp 3", f, bus.player_collision); end
      checks++; if (bus.lives !== 3'd2) begin errors++; $display("FAIL win_lives f=%0d got %0d exp 2", f, bus.lives); end
      checks++; if (bus.player_hit !== 1'(exp_hit())) begin errors++; $display("FAIL win_hit f=%0d got %0b exp %0d", f, bus.player_hit, exp_hit()); end
      checks++; if (bus.player_visible !== 1'(exp_vis())) begin errors++; $display("FAIL win_vis f=%0d got %0b exp %0d", f, bus.player_visible, exp_vis()); end
    end
    checks++; if (bus.player_hit !== 1'b0) begin errors++; $display("FAIL alive_hit got %0b exp 0", bus.player_hit); end
    do_frame();
    checks++; if (bus.lives !== 3'd1) begin errors++; $display("FAIL realive_lives got %0d exp 1", bus.lives); end
    checks++; if (bus.player_hit !== 1'b1) begin errors++; $display("FAIL realive_hit got %0b exp 1", bus.player_hit); end
  endtask

  task automatic test_game_over();
    do_restart(1'b0);
    set_pos(500, 510, 445, 0, 0, 0, 0);
    for (int f = 0; f < 3 * (HF + IF + 1) + 10; f++) begin
      do_frame();
      checks++; if (bus.lives !== 3'(m_lives)) begin errors++; $display("FAIL go_lives f=%0d got %0d exp %0d", f, bus.lives, m_lives); end
      checks++; if (bus.game_over !== 1'(m_over)) begin errors++; $display("FAIL go_flag f=%0d got %0b exp %0d", f, bus.game_over, m_over); end
    end
    checks++; if (bus.lives !== 3'd0) begin errors++; $display("FAIL go_final_lives got %0d exp 0", bus.lives); end
    checks++; if (bus.game_over !== 1'b1) begin errors++; $display("FAIL go_final got %0b exp 1", bus.game_over); end
    checks++; if (bus.player_visible !== 1'b0) begin errors++; $display("FAIL go_vis got %0b exp 0", bus.player_visible); end
    do_restart(1'b1);
    checks++; if (bus.lives !== 3'd3) begin errors++; $display("FAIL restart_lives got %0d exp 3", bus.lives); end
    checks++; if (bus.game_over !== 1'b0) begin errors++; $display("FAIL restart_go got %0b exp 0", bus.game_over); end
    checks++; if (bus.player_collision !== 2'd0) begin errors++; $display("FAIL restart_coll got %0d exp 0", bus.player_collision); end
  endtask

  task automatic test_random();
    int px, x[3], y[3];
    for (int i = 0; i < 700; i++) begin
      px = (i % 5 == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 1023));
      for (int j = 0; j < 3; j++) begin
        x[j] = px + int'($urandom_range(0, 64)) - 32;
        if (x[j] < 0) x[j] = 0;
        if (x[j] > 1023) x[j] = 1023;
        y[j] = int'($urandom_range(410, 470));
      end
      set_pos(px, x[0], y[0], x[1], y[1], x[2], y[2]);
      idle(int'($urandom_range(0, 2)));
      if ($urandom_range(0, 79) == 0) do_restart(1'b1);
      else do_frame();
      checks++; if (bus.player_collision !== 2'(m_coll)) begin errors++; $display("FAIL rnd_coll i=%0d got %0d exp %0d", i, bus.player_collision, m_coll); end
      checks++; if (bus.lives !== 3'(m_lives)) begin errors++; $display("FAIL rnd_lives i=%0d got %0d exp %0d", i, bus.lives, m_lives); end
      checks++; if (bus.player_hit !== 1'(exp_hit())) begin errors++; $display("FAIL rnd_hit i=%0d got %0b exp %0d", i, bus.player_hit, exp_hit()); end
      checks++; if (bus.player_visible !== 1'(exp_vis())) begin errors++; $display("FAIL rnd_vis i=%0d got %0b exp %0d", i, bus.player_visible, exp_vis()); end
      checks++; if (bus.game_over !== 1'(m_over)) begin errors++; $display("FAIL rnd_go i=%0d got %0b exp %0d", i, bus.game_over, m_over); end
    end
  endtask

  initial begin
    bus.frame   = 1'b0;
    bus.restart = 1'b0;
    set_pos(300, 0, 0, 0, 0, 0, 0);
    m_fno = 0;
    model_restart();
    test_reset();
    test_basic_hit();
    test_edges();
    test_priority_windows();
    test_game_over();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
